// File: rtl/ship_key_scheduler_if.sv
// Per-frame command channel from the key scheduler to the game FSM.
interface ship_key_scheduler_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [4:0] p1_cmd;
   logic [4:0] p2_cmd;

   modport master (output cmd_valid, output p1_cmd, output p2_cmd, input cmd_ready);
   modport slave  (input cmd_valid, input p1_cmd, input p2_cmd, output cmd_ready);
endinterface

// File: rtl/ship_key_scheduler.sv
// PS/2 scan-byte parser, held-key map and once-per-frame gated ship command issue.
//
// state   | meaning
// IDLE    | waiting for a make code or a prefix byte
// EXT     | E0 seen, next byte is an extended make (or F0)
// BRK     | F0 seen, next byte is a non-extended break
// EXT_BRK | E0 F0 seen, next byte is an extended break
module ship_key_scheduler #(
   parameter int unsigned FIRE_COOLDOWN  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [7:0]                  rx_data,
   input  logic                        rx_done_tick,
   input  logic                        frame_tick,
   ship_key_scheduler_if.master        cmd,
   output logic [9:0]                  held_keys,
   output logic                        overrun,
   output logic                        parse_err
);
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t          state;
   logic [WD_W-1:0] wd_cnt;
   logic [1:0]      fire_latch;
   logic [1:0]      fire_set;
   logic [1:0]      fire_out;
   logic [7:0]      cooldown [2];
   logic [9:0]      ne_mask;
   logic [9:0]      ex_mask;
   logic [4:0]      snap_p1;
   logic [4:0]      snap_p2;

   // Bit positions: {p2 fire, up, down, left, right, p1 fire, up, down, left, right}
   function automatic logic [9:0] plain_key(input logic [7:0] b);
      case (b)
         8'h23:   return 10'b00000_00001;
         8'h1C:   return 10'b00000_00010;
         8'h1B:   return 10'b00000_00100;
         8'h1D:   return 10'b00000_01000;
         8'h29:   return 10'b00000_10000;
         8'h5A:   return 10'b10000_00000;
         default: return 10'b0;
      endcase
   endfunction

   function automatic logic [9:0] ext_key(input logic [7:0] b);
      case (b)
         8'h74:   return 10'b00001_00000;
         8'h6B:   return 10'b00010_00000;
         8'h72:   return 10'b00100_00000;
         8'h75:   return 10'b01000_00000;
         default: return 10'b0;
      endcase
   endfunction

   // Opposing directions held together cancel each other.
   function automatic logic [3:0] dir_bits(input logic [3:0] h);
      return {h[3] & ~h[2], h[2] & ~h[3], h[1] & ~h[0], h[0] & ~h[1]};
   endfunction

   always_comb begin
      ne_mask     = plain_key(rx_data);
      ex_mask     = ext_key(rx_data);
      fire_set[0] = rx_done_tick && (state == IDLE) && (rx_data == 8'h29);
      fire_set[1] = rx_done_tick && (state == IDLE) && (rx_data == 8'h5A);
      fire_out[0] = (held_keys[4] | fire_latch[0]) & (cooldown[0] == 8'd0);
      fire_out[1] = (held_keys[9] | fire_latch[1]) & (cooldown[1] == 8'd0);
      snap_p1     = {fire_out[0], dir_bits(held_keys[3:0])};
      snap_p2     = {fire_out[1], dir_bits(held_keys[8:5])};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         held_keys <= '0;
         wd_cnt    <= '0;
         parse_err <= 1'b0;
      end else begin
         parse_err <= 1'b0;
         if (rx_done_tick) begin
            wd_cnt <= '0;
            case (state)
               IDLE: begin
                  if (rx_data == 8'hE0)      state <= EXT;
                  else if (rx_data == 8'hF0) state <= BRK;
                  else                       held_keys <= held_keys | ne_mask;
               end
               EXT: begin
                  if (rx_data == 8'hF0) state <= EXT_BRK;
                  else if (rx_data != 8'hE0) begin
                     held_keys <= held_keys | ex_mask;
                     state     <= IDLE;
                  end
               end
               BRK: begin
                  held_keys <= held_keys & ~ne_mask;
                  state     <= IDLE;
               end
               EXT_BRK: begin
                  held_keys <= held_keys & ~ex_mask;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            // A truncated prefix is dropped without touching the held map.
            if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
               state     <= IDLE;
               parse_err <= 1'b1;
               wd_cnt    <= '0;
            end else begin
               wd_cnt <= wd_cnt + WD_W'(1);
            end
         end else begin
            wd_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd.cmd_valid <= 1'b0;
         cmd.p1_cmd    <= '0;
         cmd.p2_cmd    <= '0;
         overrun       <= 1'b0;
         fire_latch    <= '0;
         cooldown[0]   <= '0;
         cooldown[1]   <= '0;
      end else begin
         overrun <= 1'b0;
         if (frame_tick) begin
            cmd.p1_cmd    <= snap_p1;
            cmd.p2_cmd    <= snap_p2;
            cmd.cmd_valid <= 1'b1;
            overrun       <= cmd.cmd_valid & ~cmd.cmd_ready;
            // A fire make in the snapshot cycle survives into the next frame.
            fire_latch    <= fire_set;
            for (int p = 0; p < 2; p++) begin
               if (fire_out[p])               cooldown[p] <= 8'(FIRE_COOLDOWN);
               else if (cooldown[p] != 8'd0) cooldown[p] <= cooldown[p] - 8'd1;
            end
         end else begin
            fire_latch <= fire_latch | fire_set;
            if (cmd.cmd_valid && cmd.cmd_ready) cmd.cmd_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/ship_key_scheduler.md
Name: ship_key_scheduler

Overview:
Controller between the PS/2 byte receiver and the game logic for up to two ships. It parses raw scan bytes, including make, break (F0) and extended (E0) prefixes, into a live held-key map. Once per frame it issues a gated movement/fire command to the game FSM over a valid/ready handshake. Fire is rate-limited per player by a frame-based cooldown, and a watchdog recovers the parser from truncated sequences.

Parameters:
FIRE_COOLDOWN, 8, frames a player must wait after an issued shot before fire can be issued again (legal range 1..255)
TIMEOUT_CYCLES, 1000000, clk cycles allowed between prefix bytes before the parser aborts (20 ms at 50 MHz)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received scan byte, valid only while rx_done_tick is high
rx_done_tick  in  1  one-cycle strobe: rx_data holds a new byte
frame_tick  in  1  one-cycle strobe at the start of each game frame
cmd_ready  in  1  game FSM accepts the command
cmd_valid  out  1  command registers hold an unaccepted command
p1_cmd  out  5  player 1 {fire, up, down, left, right}
p2_cmd  out  5  player 2 {fire, up, down, left, right}
held_keys  out  10  live held map {p2 fire, up, down, left, right, p1 fire, up, down, left, right}
overrun  out  1  one-cycle pulse: an unaccepted command was overwritten
parse_err  out  1  one-cycle pulse: parser watchdog fired

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-high. All outputs, held_keys, fire latches, cooldown counters and the watchdog clear to 0. Parser state returns to IDLE. Reset asserted mid-sequence discards the partial prefix.
- Key map, non-extended codes: 1C = p1 left, 23 = p1 right, 1B = p1 down, 1D = p1 up, 29 = p1 fire, 5A = p2 fire.
- Key map, E0-prefixed codes: 6B = p2 left, 74 = p2 right, 72 = p2 down, 75 = p2 up.
- An unmapped code, or a mapped code with the wrong prefix, consumes the sequence and changes nothing.
- Parser FSM, 2-bit, advances only on rx_done_tick:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make in the non-extended set -> IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT (stay); other byte is an extended make -> IDLE.
  - BRK: byte is a non-extended break -> IDLE.
  - EXT_BRK: byte is an extended break -> IDLE.
  - Make sets the held bit. Break clears it. Make of a fire key also sets that player's fire_latch.
  - Bytes AA, FA, FE, EE and E1 in IDLE are ignored.
- Watchdog: counts clk cycles while the parser is not in IDLE and clears on every rx_done_tick. On reaching TIMEOUT_CYCLES-1 it forces IDLE, pulses parse_err for one cycle and leaves held_keys unchanged.
- held_keys is registered: it updates the cycle after rx_done_tick.
- Frame snapshot, on frame_tick, per player:
  - Direction bits come from the registered held map. If left and right are both held, both report 0; the same rule applies to up and down.
  - fire_out = (held_fire | fire_latch) & (cooldown == 0).
  - If fire_out is 1, cooldown loads FIRE_COOLDOWN. Otherwise, if cooldown > 0, it decrements by 1.
  - fire_latch clears.
  - p1_cmd and p2_cmd are loaded and cmd_valid is set. Command latency is 1 cycle after frame_tick.
- Handshake: the transfer completes on a cycle with cmd_valid & cmd_ready, and cmd_valid drops the next cycle.
  - p1_cmd and p2_cmd hold stable while cmd_valid=1.
  - If frame_tick arrives while cmd_valid=1 and cmd_ready=0, the command registers are overwritten, cmd_valid stays 1 and overrun pulses.
  - If frame_tick coincides with cmd_ready=1, the new command loads and cmd_valid stays 1.
- Simultaneous rx_done_tick and frame_tick: the snapshot uses the pre-byte held map. The byte still updates the held map in the same cycle. A fire make arriving in that cycle sets fire_latch, and the set wins over the clear.
- A press and release both between two frame_ticks still yields one fire through fire_latch, subject to cooldown.

Test Plan:
- Reset, then frame_tick with cmd_ready=1 -> cmd_valid=1 one cycle later; p1_cmd=00000, p2_cmd=00000, held_keys=0.
- Bytes 1D then 23, then frame_tick -> p1_cmd=01001. Then F0 1D and a frame_tick -> p1_cmd=00001.
- Bytes E0 6B, then E0 74, then frame_tick -> p2_cmd=00000 (left/right cancel). Then E0 F0 74 and a frame_tick -> p2_cmd=00010.
- Hold 29 across 20 frames with FIRE_COOLDOWN=8 -> p1 fire=1 on frames 0, 9 and 18 only. Separately, byte 29 then F0 29 within one frame -> fire=1 on the next frame.
- Byte E0 only, then silence for TIMEOUT_CYCLES -> parse_err pulses once. A following byte 75 is treated as a non-extended make and is ignored (p2 up stays 0).
- cmd_ready=0 across two frame_ticks -> overrun pulses on the second, and cmd_valid stays 1 holding the newer command. A reset pulse mid-E0-F0 sequence -> all outputs 0 and the parser back in IDLE.
